// File: rtl/motor_pwm_driver_pkg.sv
// Shared types and defaults for the motor PWM driver and the host register map.
// Holds the controller state enum and the default ramp / dead-time constants.
package motor_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        BRAKE,
        DEAD
    } state_t;

    localparam int DEF_CNT_W       = 32;
    localparam int DEF_RAMP_STEP   = 1;
    localparam int DEF_DEAD_CYCLES = 1000;

endpackage

// File: rtl/motor_pwm_driver_if.sv
// Host/driver bundle for the motor PWM driver.
// master: drives enable, pwm_period, duty_target, dir_cmd; reads status.
// slave : the driver; reads the commands, drives pwm_out, dir_out, busy, at_target.
interface motor_pwm_driver_if #(
    parameter int CNT_W = 32
);
    logic             enable;
    logic [CNT_W-1:0] pwm_period;
    logic [CNT_W-1:0] duty_target;
    logic             dir_cmd;
    logic             pwm_out;
    logic             dir_out;
    logic             busy;
    logic             at_target;

    modport master (
        output enable, pwm_period, duty_target, dir_cmd,
        input  pwm_out, dir_out, busy, at_target
    );

    modport slave (
        input  enable, pwm_period, duty_target, dir_cmd,
        output pwm_out, dir_out, busy, at_target
    );
endinterface

// File: rtl/motor_pwm_driver_duty_slew.sv
// Saturating step-toward-target unit: moves i_cur toward i_target by at most i_step.
// Ports: i_cur, i_target, i_step, i_dir_down (direction of travel) -> o_next.
module duty_slew #(
    parameter int CNT_W = 32
) (
    input  logic [CNT_W-1:0] i_cur,
    input  logic [CNT_W-1:0] i_target,
    input  logic [CNT_W-1:0] i_step,
    input  logic             i_dir_down,
    output logic [CNT_W-1:0] o_next
);
    logic [CNT_W-1:0] w_diff;
    logic [CNT_W-1:0] w_move;

    always_comb begin
        w_diff = '0;
        // A target on the wrong side of i_cur yields no movement.
        if (i_dir_down && (i_cur > i_target)) begin
            w_diff = i_cur - i_target;
        end else if (!i_dir_down && (i_target > i_cur)) begin
            w_diff = i_target - i_cur;
        end
        w_move = (w_diff < i_step) ? w_diff : i_step;
        o_next = i_dir_down ? (i_cur - w_move) : (i_cur + w_move);
    end
endmodule

// File: rtl/motor_pwm_driver.sv
// PWM generator for the motor H-bridge with duty slew and guarded reversal.
// Ports: clk, reset (async, active-high), bus (slave modport: commands in, pins/status out).
module motor_pwm_driver
    import motor_pkg::*;
#(
    parameter int CNT_W       = DEF_CNT_W,
    parameter int RAMP_STEP   = DEF_RAMP_STEP,
    parameter int DEAD_CYCLES = DEF_DEAD_CYCLES
) (
    input logic                clk,
    input logic                reset,
    motor_pwm_driver_if.slave  bus
);
    localparam int DW = $clog2(DEAD_CYCLES) + 1;
    localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);
    localparam logic [CNT_W-1:0] STEP      = CNT_W'(RAMP_STEP);
    localparam logic [DW-1:0]    ONE_D     = DW'(1);
    localparam logic [DW-1:0]    DEAD_INIT = DW'(DEAD_CYCLES - 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_period_q;
    logic [CNT_W-1:0] r_duty_cur;
    logic [DW-1:0]    r_dead_cnt;
    logic             r_dir;
    logic             r_pwm;
    logic             r_at;

    state_t           w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_period_nxt;
    logic [CNT_W-1:0] w_duty_nxt;
    logic [DW-1:0]    w_dead_nxt;
    logic             w_dir_nxt;
    logic             w_pwm_nxt;
    logic             w_at_nxt;

    logic [CNT_W-1:0] w_period_in;
    logic [CNT_W-1:0] w_slew_tgt;
    logic [CNT_W-1:0] w_slew_next;
    logic             w_slew_down;
    logic             w_wrap;
    logic             w_run_ok;

    // A programmed period of 0 runs as 1 (two-cycle period).
    assign w_period_in = (bus.pwm_period == '0) ? ONE_C : bus.pwm_period;
    assign w_wrap      = (r_cnt == r_period_q);
    assign w_run_ok    = bus.enable && (bus.dir_cmd == r_dir);

    // One slew unit serves both the RUN seek and the BRAKE ramp to zero.
    assign w_slew_tgt  = (r_state == BRAKE) ? '0 : bus.duty_target;
    assign w_slew_down = (r_state == BRAKE) || (bus.duty_target < r_duty_cur);

    duty_slew #(.CNT_W(CNT_W)) u_slew (
        .i_cur      (r_duty_cur),
        .i_target   (w_slew_tgt),
        .i_step     (STEP),
        .i_dir_down (w_slew_down),
        .o_next     (w_slew_next)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_period_q <= '0;
            r_duty_cur <= '0;
            r_dead_cnt <= '0;
            r_dir      <= 1'b0;
            r_pwm      <= 1'b0;
            r_at       <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_period_q <= w_period_nxt;
            r_duty_cur <= w_duty_nxt;
            r_dead_cnt <= w_dead_nxt;
            r_dir      <= w_dir_nxt;
            r_pwm      <= w_pwm_nxt;
            r_at       <= w_at_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_period_nxt = r_period_q;
        w_duty_nxt   = r_duty_cur;
        w_dead_nxt   = r_dead_cnt;
        w_dir_nxt    = r_dir;
        w_pwm_nxt    = 1'b0;

        unique case (r_state)
            IDLE: begin
                w_cnt_nxt  = '0;
                w_duty_nxt = '0;
                if (bus.enable) begin
                    w_state_nxt  = RUN;
                    w_dir_nxt    = bus.dir_cmd;
                    w_period_nxt = w_period_in;
                end
            end
            RUN, BRAKE: begin
                w_pwm_nxt = (r_cnt < r_duty_cur);
                if (w_wrap) begin
                    w_cnt_nxt    = '0;
                    w_period_nxt = w_period_in;
                    w_duty_nxt   = w_slew_next;
                end else begin
                    w_cnt_nxt = r_cnt + ONE_C;
                end
                if (r_state == RUN) begin
                    if (!w_run_ok) begin
                        w_state_nxt = BRAKE;
                    end
                end else if (w_run_ok) begin
                    // Command restored before reaching zero: resume without dead time.
                    w_state_nxt = RUN;
                end else if (r_duty_cur == '0) begin
                    w_state_nxt = DEAD;
                    w_dead_nxt  = DEAD_INIT;
                    w_cnt_nxt   = '0;
                end
            end
            DEAD: begin
                w_cnt_nxt = '0;
                if (r_dead_cnt != '0) begin
                    w_dead_nxt = r_dead_cnt - ONE_D;
                end else if (bus.enable) begin
                    w_state_nxt = RUN;
                    w_dir_nxt   = bus.dir_cmd;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        // Registered so status has no combinational path from the host inputs.
        w_at_nxt = (w_state_nxt == RUN) && (w_duty_nxt == bus.duty_target);
    end

    assign bus.pwm_out   = r_pwm;
    assign bus.dir_out   = r_dir;
    assign bus.busy      = (r_state != IDLE);
    assign bus.at_target = r_at;

endmodule

// File: tb/tb_motor_pwm_driver.sv
// Randomized and directed bench for motor_pwm_driver against a behavioural model.
// Two instances (different ramp step / dead time) share the same host stimulus.
module tb_motor_pwm_driver;

    localparam int W    = 8;
    localparam int ST_A = 3;
    localparam int DC_A = 7;
    localparam int ST_B = 1;
    localparam int DC_B = 5;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_BRAKE = 2;
    localparam int M_DEAD  = 3;

    typedef struct {
        int st;
        int cnt;
        int per;
        int duty;
        int dead;
        int dir;
        int pwm;
        int at;
    } mdl_t;

    logic         clk = 1'b0;
    logic         reset;
    logic         en;
    logic         dc;
    logic [W-1:0] per;
    logic [W-1:0] tgt;

    int   n_chk = 0;
    int   n_err = 0;
    int   hi_a;
    int   hi_b;
    int   found;
    logic pd_a;
    logic pd_b;
    mdl_t ma;
    mdl_t mb;

    motor_pwm_driver_if #(.CNT_W(W)) if_a ();
    motor_pwm_driver_if #(.CNT_W(W)) if_b ();

    assign if_a.enable      = en;
    assign if_a.pwm_period  = per;
    assign if_a.duty_target = tgt;
    assign if_a.dir_cmd     = dc;
    assign if_b.enable      = en;
    assign if_b.pwm_period  = per;
    assign if_b.duty_target = tgt;
    assign if_b.dir_cmd     = dc;

    motor_pwm_driver #(
        .CNT_W(W), .RAMP_STEP(ST_A), .DEAD_CYCLES(DC_A)
    ) dut_a (
        .clk(clk), .reset(reset), .bus(if_a)
    );

    motor_pwm_driver #(
        .CNT_W(W), .RAMP_STEP(ST_B), .DEAD_CYCLES(DC_B)
    ) dut_b (
        .clk(clk), .reset(reset), .bus(if_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic mdl_t mreset();
        mdl_t m;
        m = '{default: 0};
        return m;
    endfunction

    // State of the motor after one clock, from the behavioural rules.
    function automatic mdl_t mstep(input mdl_t m, input int step, input int dcy,
                                   input int e, input int p, input int t, input int d);
        mdl_t n;
        int   lat;
        int   dlt;
        n   = m;
        lat = (p == 0) ? 1 : p;
        n.pwm = ((m.st == M_RUN || m.st == M_BRAKE) && m.cnt < m.duty) ? 1 : 0;
        if (m.st == M_IDLE) begin
            n.cnt  = 0;
            n.duty = 0;
            if (e != 0) begin
                n.st  = M_RUN;
                n.dir = d;
                n.per = lat;
            end
        end else if (m.st == M_DEAD) begin
            n.cnt = 0;
            if (m.dead > 0) begin
                n.dead = m.dead - 1;
            end else if (e != 0) begin
                n.st  = M_RUN;
                n.dir = d;
            end else begin
                n.st = M_IDLE;
            end
        end else begin
            if (m.cnt == m.per) begin
                n.cnt = 0;
                n.per = lat;
                if (m.st == M_RUN) begin
                    dlt = t - m.duty;
                    if (dlt > step) dlt = step;
                    if (dlt < -step) dlt = -step;
                    n.duty = m.duty + dlt;
                end else begin
                    n.duty = (m.duty > step) ? m.duty - step : 0;
                end
            end else begin
                n.cnt = m.cnt + 1;
            end
            if (m.st == M_RUN) begin
                if (e == 0 || d != m.dir) n.st = M_BRAKE;
            end else if (e != 0 && d == m.dir) begin
                n.st = M_RUN;
            end else if (m.duty == 0) begin
                n.st   = M_DEAD;
                n.dead = dcy - 1;
                n.cnt  = 0;
            end
        end
        n.at = (n.st == M_RUN && n.duty == t) ? 1 : 0;
        return n;
    endfunction

    task automatic compare();
        check("pwm_a",  int'(if_a.pwm_out),   ma.pwm);
        check("dir_a",  int'(if_a.dir_out),   ma.dir);
        check("busy_a", int'(if_a.busy),      (ma.st != M_IDLE) ? 1 : 0);
        check("at_a",   int'(if_a.at_target), ma.at);
        check("pwm_b",  int'(if_b.pwm_out),   mb.pwm);
        check("dir_b",  int'(if_b.dir_out),   mb.dir);
        check("busy_b", int'(if_b.busy),      (mb.st != M_IDLE) ? 1 : 0);
        check("at_b",   int'(if_b.at_target), mb.at);
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            ma = mstep(ma, ST_A, DC_A, int'(en), int'(per), int'(tgt), int'(dc));
            mb = mstep(mb, ST_B, DC_B, int'(en), int'(per), int'(tgt), int'(dc));
            pd_a = if_a.dir_out;
            pd_b = if_b.dir_out;
            @(negedge clk);
            compare();
            hi_a += int'(if_a.pwm_out);
            hi_b += int'(if_b.pwm_out);
            if (if_a.dir_out != pd_a) check("flip_low_a", int'(if_a.pwm_out), 0);
            if (if_b.dir_out != pd_b) check("flip_low_b", int'(if_b.pwm_out), 0);
        end
    endtask

    task automatic window(input string tag, input int exp);
        hi_a = 0;
        hi_b = 0;
        tick(10);
        check({tag, "_a"}, hi_a, exp);
        check({tag, "_b"}, hi_b, exp);
    endtask

    initial begin
        reset = 1'b1;
        en    = 1'b0;
        dc    = 1'b0;
        per   = '0;
        tgt   = '0;
        ma    = mreset();
        mb    = mreset();
        repeat (2) @(negedge clk);
        compare();
        reset = 1'b0;

        per = 8'd9;
        tgt = 8'd3;
        en  = 1'b1;
        tick(40);
        window("hi_d3", 3);
        check("at_d3_a", int'(if_a.at_target), 1);

        tgt = 8'd12;
        tick(120);
        window("hi_full", 10);

        tgt = 8'd0;
        tick(150);
        window("hi_zero", 0);

        per = 8'd0;
        tgt = 8'd1;
        tick(30);
        window("hi_p0", 5);

        en = 1'b0;
        tick(40);
        check("idle_a", int'(if_a.busy), 0);
        check("idle_b", int'(if_b.busy), 0);

        per = 8'd9;
        tgt = 8'd4;
        en  = 1'b1;
        tick(60);

        dc = 1'b1;
        tick(120);
        check("rev_dir_b", int'(if_b.dir_out), 1);

        tgt = 8'd8;
        tick(120);
        en = 1'b0;
        tick(15);
        en = 1'b1;
        tick(40);

        found = 0;
        for (int i = 0; i < 50 && found == 0; i++) begin
            tick(1);
            if (if_a.pwm_out == 1'b1) found = 1;
        end
        check("pwm_high_seen", found, 1);
        #1 reset = 1'b1;
        #1;
        check("rst_pwm_a",  int'(if_a.pwm_out), 0);
        check("rst_dir_a",  int'(if_a.dir_out), 0);
        check("rst_busy_a", int'(if_a.busy),    0);
        check("rst_pwm_b",  int'(if_b.pwm_out), 0);
        check("rst_dir_b",  int'(if_b.dir_out), 0);
        check("rst_busy_b", int'(if_b.busy),    0);
        ma = mreset();
        mb = mreset();
        en = 1'b0;
        @(negedge clk);
        compare();
        reset = 1'b0;
        tick(20);
        en = 1'b1;
        tick(20);

        for (int k = 0; k < 300; k++) begin
            if ($urandom_range(0, 3) == 0) en = ~en;
            if ($urandom_range(0, 5) == 0) dc = ~dc;
            if ($urandom_range(0, 3) == 0)
                per = W'($urandom_range(245, 255));
            else
                per = W'($urandom_range(0, 12));
            if ($urandom_range(0, 7) == 0)
                tgt = 8'd255;
            else
                tgt = W'($urandom_range(0, 16));
            tick(int'($urandom_range(1, 40)));
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
